max7219_chain_rx: RTL

- Receiver and register model for a daisy-chain of MAX7219 LED-matrix drivers.
- Deserialises the 3-wire SPI bundle (clock, data, chip select) produced by the matrix SPI driver and latches one 16-bit command per device when chip select rises.
- Keeps each device's digit and control registers, exposed through a registered read port.
- Used on-chip as a loopback checker for the matrix driver, and as a display emulator feeding an on-board LED or debug readout.

---
 rtl/max7219_chain_rx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/max7219_chain_rx.sv
// max7219_chain_rx: receiver and register model for a daisy chain of MAX7219
// LED-matrix drivers. It deserialises the 3-wire SPI bundle and, when chip
// select rises, latches one 16-bit command per device. The per-device
// registers are exposed through a registered read port.
//
// Ports:
//   clk_in       system clock, rising edge
//   rst_in       synchronous active-high reset
//   spi_in       [0] SCLK, [1] DIN, [2] CS_n (asynchronous to clk_in)
//   rd_dev       device index to read
//   rd_addr      register address to read
//   rd_data      registered read data (1-cycle latency)
//   frame_valid  one-cycle pulse: a complete frame was committed
//   frame_err    one-cycle pulse: frame discarded because of a wrong bit count
//   upd_mask     devices written by the last committed frame
//   bit_cnt      bits received in the current frame (saturating)
module max7219_chain_rx #(
    parameter int unsigned N_DEV = 8,
    parameter int unsigned DEV_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [2:0]       spi_in,
    input  logic [DEV_W-1:0] rd_dev,
    input  logic [3:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [N_DEV-1:0] upd_mask,
    output logic [15:0]      bit_cnt
);

    localparam int unsigned FRAME_W    = 16 * N_DEV;
    localparam logic [15:0] FRAME_BITS = 16'(FRAME_W);
    localparam logic [2:0]  BUS_IDLE   = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT, S_ERROR} state_t;

    state_t             r_state;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_prev;
    logic [FRAME_W-1:0] r_shift;

    logic [7:0] r_digit     [N_DEV][8];
    logic [7:0] r_decode    [N_DEV];
    logic [3:0] r_intensity [N_DEV];
    logic [2:0] r_scan      [N_DEV];
    logic       r_shdn_n    [N_DEV];
    logic       r_test      [N_DEV];

    logic       w_sclk_rise;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_sample;
    logic [3:0] w_addr [N_DEV];
    logic [7:0] w_data [N_DEV];
    logic [N_DEV-1:0] w_upd;
    logic [7:0] w_rd_val;
    logic       w_unused;

    // Edge detection on the synchronised bus
    assign w_sclk_rise = r_sync2[0] & ~r_prev[0];
    assign w_cs_fall   = ~r_sync2[2] & r_prev[2];
    assign w_cs_rise   = r_sync2[2] & ~r_prev[2];
    // CS_n must be low on both samples, so an SCLK edge coincident with a CS_n edge is dropped
    assign w_sample    = w_sclk_rise & ~r_sync2[2] & ~r_prev[2];

    // Per-device word split; device k owns word bits [16k+15:16k]
    always_comb begin
        w_upd    = '0;
        w_unused = r_prev[1];
        for (int k = 0; k < N_DEV; k++) begin
            w_addr[k] = r_shift[16*k+8 +: 4];
            w_data[k] = r_shift[16*k +: 8];
            w_unused  = w_unused ^ (^r_shift[16*k+12 +: 4]);
            case (w_addr[k])
                4'h0, 4'hD, 4'hE: w_upd[k] = 1'b0;
                default:          w_upd[k] = 1'b1;
            endcase
        end
    end

    // Read mux; unmatched devices and addresses return zero
    always_comb begin
        w_rd_val = 8'h00;
        for (int k = 0; k < N_DEV; k++) begin
            if (rd_dev == DEV_W'(k)) begin
                case (rd_addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: w_rd_val = r_digit[k][3'(rd_addr - 4'd1)];
                    4'h9:                   w_rd_val = r_decode[k];
                    4'hA:                   w_rd_val = {4'h0, r_intensity[k]};
                    4'hB:                   w_rd_val = {5'h00, r_scan[k]};
                    4'hC:                   w_rd_val = {7'h00, r_shdn_n[k]};
                    4'hF:                   w_rd_val = {7'h00, r_test[k]};
                    default:                w_rd_val = 8'h00;
                endcase
            end
        end
    end

    // Synchronisers, frame FSM, register file and read port
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_sync1     <= BUS_IDLE;
            r_sync2     <= BUS_IDLE;
            r_prev      <= BUS_IDLE;
            r_shift     <= '0;
            rd_data     <= 8'h00;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            upd_mask    <= '0;
            bit_cnt     <= 16'h0000;
            for (int k = 0; k < N_DEV; k++) begin
                for (int j = 0; j < 8; j++) begin
                    r_digit[k][j] <= 8'h00;
                end
                r_decode[k]    <= 8'h00;
                r_intensity[k] <= 4'h0;
                r_scan[k]      <= 3'h0;
                r_shdn_n[k]    <= 1'b0;
                r_test[k]      <= 1'b0;
            end
        end else begin
            r_sync1     <= spi_in;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            rd_data     <= w_rd_val;

            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        bit_cnt <= 16'h0000;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_cs_rise) begin
                        if (bit_cnt == FRAME_BITS) begin
                            frame_valid <= 1'b1;
                            upd_mask    <= w_upd;
                            r_state     <= S_COMMIT;
                            for (int k = 0; k < N_DEV; k++) begin
                                case (w_addr[k])
                                    4'h1, 4'h2, 4'h3, 4'h4,
                                    4'h5, 4'h6, 4'h7, 4'h8:
                                        r_digit[k][3'(w_addr[k] - 4'd1)] <= w_data[k];
                                    4'h9: r_decode[k]    <= w_data[k];
                                    4'hA: r_intensity[k] <= w_data[k][3:0];
                                    4'hB: r_scan[k]      <= w_data[k][2:0];
                                    4'hC: r_shdn_n[k]    <= w_data[k][0];
                                    4'hF: r_test[k]      <= w_data[k][0];
                                    default: ;
                                endcase
                            end
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_ERROR;
                        end
                    end else if (w_sample) begin
                        r_shift <= {r_shift[FRAME_W-2:0], r_sync2[1]};
                        if (bit_cnt != 16'hFFFF) begin
                            bit_cnt <= bit_cnt + 16'd1;
                        end
                    end
                end
                S_COMMIT, S_ERROR: begin
                    // A new frame may start immediately after the pulse cycle
                    if (w_cs_fall) begin
                        bit_cnt <= 16'h0000;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
